// File: rtl/backchannel_report_sched_if.sv
// Signal bundle between the backchannel report scheduler and its UART, register-file and Thunderbolt neighbours.
// master = scheduler side, slave = surrounding logic.
interface backchannel_report_sched_if;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic [7:0] o_reg_addr;
  logic [7:0] i_reg_data;
  logic [2:0] o_tim_idx;
  logic [7:0] i_tim_data;
  logic       i_tim_valid;
  logic       o_tim_freeze;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_active;
  logic       i_tx_done;
  logic       o_busy;
  logic       o_cmd_err;

  modport master (
    input  i_rx_dv, i_rx_byte, i_reg_data, i_tim_data, i_tim_valid, i_tx_active, i_tx_done,
    output o_reg_addr, o_tim_idx, o_tim_freeze, o_tx_dv, o_tx_byte, o_busy, o_cmd_err
  );

  modport slave (
    output i_rx_dv, i_rx_byte, i_reg_data, i_tim_data, i_tim_valid, i_tx_active, i_tx_done,
    input  o_reg_addr, o_tim_idx, o_tim_freeze, o_tx_dv, o_tx_byte, o_busy, o_cmd_err
  );
endinterface

// File: rtl/backchannel_report_sched.sv
// Command-driven report scheduler for the user backchannel UART (register dump, Thunderbolt dump, echo).
// Optional XOR trailer byte enabled by defining BACKCHANNEL_CHECKSUM_EN.
module backchannel_report_sched #(
  parameter int         REG_COUNT = 21,
  parameter int         TIM_BYTES = 7,
  parameter logic [7:0] CMD_REG   = 8'hAB,
  parameter logic [7:0] CMD_TIM   = 8'hAC,
  parameter logic [7:0] CMD_ECHO  = 8'hEE
) (
  input  logic                               i_clk_10,
  input  logic                               i_rst_n,
  backchannel_report_sched_if.master         bus,
  output logic [2:0]                         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_WAIT_RD, S_SEND, S_WAIT_DONE, S_NEXT
  } state_t;

  typedef enum logic [1:0] {PH_HDR, PH_PAY, PH_TRL} phase_t;

  // Handshake to the UART tx: o_tx_dv is a single-cycle strobe raised only in SEND while
  // i_tx_active is low; o_tx_byte holds until i_tx_done, which is honoured only in WAIT_DONE.

  state_t     state, state_nxt;
  phase_t     phase;
  logic       slot_valid;
  logic [7:0] slot_cmd;
  logic [7:0] cmd;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] pay_len;
  logic [7:0] rd_byte;
  logic       tim_ok;
  logic       rx_known, rx_direct, rx_store, rx_reject;
  logic       more_payload, trailer_due;
`ifdef BACKCHANNEL_CHECKSUM_EN
  logic [7:0] acc;
`endif

  always_comb begin
    rx_known  = (bus.i_rx_byte == CMD_REG) || (bus.i_rx_byte == CMD_TIM) ||
                (bus.i_rx_byte == CMD_ECHO);
    // In IDLE an accepted byte bypasses the slot: capture and pop collapse into one cycle.
    rx_direct = bus.i_rx_dv && rx_known && !slot_valid && (state == S_IDLE);
    rx_store  = bus.i_rx_dv && rx_known && !slot_valid && (state != S_IDLE);
    rx_reject = bus.i_rx_dv && (!rx_known || slot_valid);
  end

  always_comb begin
    pay_len = 8'd0;
    if (cmd == CMD_REG)      pay_len = 8'(REG_COUNT);
    else if (cmd == CMD_TIM) pay_len = 8'(TIM_BYTES);
  end

  always_comb begin
    more_payload = 1'b0;
    if (phase == PH_HDR)      more_payload = (pay_len != 8'd0);
    else if (phase == PH_PAY) more_payload = (cnt < pay_len - 8'd1);
    cnt_nxt = (phase == PH_HDR) ? 8'd0 : cnt + 8'd1;
`ifdef BACKCHANNEL_CHECKSUM_EN
    trailer_due = (phase != PH_TRL);
`else
    trailer_due = 1'b0;
`endif
  end

  always_comb begin
    rd_byte = 8'h00;
    if (cmd == CMD_REG)             rd_byte = bus.i_reg_data;
    else if (cmd == CMD_TIM && tim_ok) rd_byte = bus.i_tim_data;
  end

  // State register
  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (slot_valid || rx_direct) state_nxt = S_START;
      S_START:     state_nxt = S_SEND;
      S_FETCH:     state_nxt = S_WAIT_RD;
      S_WAIT_RD:   state_nxt = S_SEND;
      S_SEND:      if (!bus.i_tx_active) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.i_tx_done) state_nxt = S_NEXT;
      S_NEXT: begin
        if (more_payload)     state_nxt = S_FETCH;
        else if (trailer_due) state_nxt = S_SEND;
        else                  state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.o_busy       = (state != S_IDLE);
    bus.o_tx_dv      = (state == S_SEND) && !bus.i_tx_active;
    // Freeze drops once the last payload byte is done, before any trailer.
    bus.o_tim_freeze = (state != S_IDLE) && (cmd == CMD_TIM) && (phase != PH_TRL) &&
                       !((state == S_NEXT) && !more_payload);
    dbg_state        = state;
  end

  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_valid     <= 1'b0;
      slot_cmd       <= 8'h00;
      cmd            <= 8'h00;
      cnt            <= 8'h00;
      phase          <= PH_HDR;
      tim_ok         <= 1'b0;
      bus.o_reg_addr <= 8'h00;
      bus.o_tim_idx  <= 3'd0;
      bus.o_tx_byte  <= 8'h00;
      bus.o_cmd_err  <= 1'b0;
`ifdef BACKCHANNEL_CHECKSUM_EN
      acc            <= 8'h00;
`endif
    end else begin
      bus.o_cmd_err <= rx_reject;
      if (state == S_IDLE && slot_valid) slot_valid <= 1'b0;
      if (rx_store) begin
        slot_valid <= 1'b1;
        slot_cmd   <= bus.i_rx_byte;
      end
      case (state)
        S_IDLE: begin
          phase <= PH_HDR;
          if (slot_valid)     cmd <= slot_cmd;
          else if (rx_direct) cmd <= bus.i_rx_byte;
        end
        S_START: begin
          cnt           <= 8'h00;
          tim_ok        <= bus.i_tim_valid;
          bus.o_tx_byte <= cmd;
`ifdef BACKCHANNEL_CHECKSUM_EN
          acc           <= cmd;
`endif
        end
        S_WAIT_RD: begin
          bus.o_tx_byte <= rd_byte;
`ifdef BACKCHANNEL_CHECKSUM_EN
          acc           <= acc ^ rd_byte;
`endif
        end
        S_NEXT: begin
          if (more_payload) begin
            cnt   <= cnt_nxt;
            phase <= PH_PAY;
            if (cmd == CMD_REG) bus.o_reg_addr <= cnt_nxt;
            if (cmd == CMD_TIM) bus.o_tim_idx  <= cnt_nxt[2:0];
          end else if (trailer_due) begin
            phase <= PH_TRL;
`ifdef BACKCHANNEL_CHECKSUM_EN
            bus.o_tx_byte <= acc;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_backchannel_report_sched.sv
// Self-checking bench for backchannel_report_sched: UART tx model, register-file and snapshot models,
// expected-byte scoreboard.
module tb_backchannel_report_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  dbg_state;
  backchannel_report_sched_if bus ();

  backchannel_report_sched dut (
    .i_clk_10 (clk),
    .i_rst_n  (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  initial forever #50 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int err_cnt  = 0;
  int done_cyc = 0;
  int hdr_dv_cyc = 0;
  int send_cyc = 0;
  int m_state  = 0;
  int m_cnt    = 0;
  logic [7:0]  m_byte;
  logic        m_stable;
  logic [17:0] e;
  logic [17:0] exp_q[$];   // {gap[7:0], busy, freeze, byte}

  logic [7:0] mem  [0:255];
  logic [7:0] snap [0:7];
  logic       model_active, hold_active;
  logic       drv_dv, inj_dv;
  logic [7:0] drv_byte, inj_byte;
  logic       inject_valid;
  logic       inject_used = 1'b0;
  logic [7:0] inject_cmd;

  assign bus.i_tx_active = model_active | hold_active;
  assign bus.i_rx_dv     = drv_dv | inj_dv;
  assign bus.i_rx_byte   = inj_dv ? inj_byte : drv_byte;
  assign bus.i_tim_data  = snap[bus.o_tim_idx];

  always @(posedge clk) bus.i_reg_data <= mem[bus.o_reg_addr];
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.o_cmd_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  task automatic push_report(input logic [7:0] c);
    logic [7:0] x, d;
    logic frz;
    int len;
    frz = (c == 8'hAC);
    x   = c;
    exp_q.push_back({8'd0, 1'b1, frz, c});
    len = (c == 8'hAB) ? 21 : (c == 8'hAC) ? 7 : 0;
    for (int i = 0; i < len; i++) begin
      if (c == 8'hAB) d = mem[i[7:0]];
      else            d = bus.i_tim_valid ? snap[i[2:0]] : 8'h00;
      x = x ^ d;
      exp_q.push_back({8'd4, 1'b1, frz, d});
    end
`ifdef BACKCHANNEL_CHECKSUM_EN
    exp_q.push_back({8'd2, 1'b1, 1'b0, x});
`endif
  endtask

  // UART tx model: accepts a strobe, goes busy for a random time, then pulses done.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_state      = 0;
      model_active = 1'b0;
      bus.i_tx_done = 1'b0;
      inj_dv       = 1'b0;
    end else begin
      bus.i_tx_done = 1'b0;
      inj_dv        = 1'b0;
      case (m_state)
        0: if (bus.o_tx_dv === 1'b1) begin
          dv_cnt++;
          m_byte   = bus.o_tx_byte;
          m_stable = 1'b1;
          if (exp_q.size() == 0) begin
            check("tx_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", bus.o_tx_byte, e[7:0]);
            check("tim_freeze", bus.o_tim_freeze, e[8]);
            check("busy_on_tx", bus.o_busy, e[9]);
            if (e[17:10] != 8'd0) check("byte_gap", cyc - done_cyc, e[17:10]);
            else hdr_dv_cyc = cyc;
          end
          m_state = 1;
        end
        1: begin
          check("tx_dv_one_cycle", bus.o_tx_dv, 0);
          model_active = 1'b1;
          m_cnt   = $urandom_range(2, 10);
          m_state = 2;
        end
        default: begin
          if (bus.o_tx_byte !== m_byte) m_stable = 1'b0;
          if (m_cnt == 0) begin
            model_active  = 1'b0;
            bus.i_tx_done = 1'b1;
            done_cyc      = cyc;
            check("tx_byte_stable", m_stable, 1);
            if (inject_valid && !inject_used && exp_q.size() == 0) begin
              inj_dv      = 1'b1;
              inj_byte    = inject_cmd;
              inject_used = 1'b1;
              push_report(inject_cmd);
            end
            m_state = 0;
          end else begin
            m_cnt--;
          end
        end
      endcase
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    drv_dv   = 1'b1;
    drv_byte = b;
    send_cyc = cyc;
    @(negedge clk);
    drv_dv   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(bus.o_busy == 1'b0 && exp_q.size() == 0 && m_state == 0 && bus.i_tx_done == 1'b0)
           && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  task automatic wait_dv(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (dv_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_reg_addr"}, bus.o_reg_addr, 0);
    check({tag, "_tim_idx"}, bus.o_tim_idx, 0);
    check({tag, "_freeze"}, bus.o_tim_freeze, 0);
    check({tag, "_tx_dv"}, bus.o_tx_dv, 0);
    check({tag, "_tx_byte"}, bus.o_tx_byte, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_cmd_err"}, bus.o_cmd_err, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int err0, dv0, lat, trl;
`ifdef BACKCHANNEL_CHECKSUM_EN
    trl = 1;
`else
    trl = 0;
`endif
    rst_n = 1'b0;
    drv_dv = 1'b0;
    drv_byte = 8'h00;
    hold_active = 1'b0;
    inject_valid = 1'b0;
    inject_cmd = 8'h00;
    bus.i_tim_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 21; i < 256; i++) mem[i] = 8'h5A;
    mem[0] = 8'd1; mem[1] = 8'd3; mem[5] = 8'd2; mem[6] = 8'd4; mem[9] = 8'd20; mem[20] = 8'd1;
    snap[0] = 8'd10; snap[1] = 8'd10; snap[2] = 8'd10; snap[3] = 8'd25;
    snap[4] = 8'd2;  snap[5] = 8'd20; snap[6] = 8'd20; snap[7] = 8'hFF;

    repeat (3) @(negedge clk);
    #1 check_reset_values("reset");
    #5 rst_n = 1'b1;

    // Echo
    err0 = err_cnt; dv0 = dv_cnt;
    push_report(8'hEE);
    send_cmd(8'hEE);
    wait_idle("echo_done", 500);
    lat = hdr_dv_cyc - send_cyc;
    check("echo_latency_le3", (lat >= 1 && lat <= 3), 1);
    check("echo_dv_count", dv_cnt - dv0, 1 + trl);
    check("echo_busy_low", bus.o_busy, 0);
    check("echo_no_err", err_cnt - err0, 0);

    // Register dump
    dv0 = dv_cnt;
    push_report(8'hAB);
    send_cmd(8'hAB);
    wait_idle("reg_done", 2000);
    check("reg_dv_count", dv_cnt - dv0, 22 + trl);

    // Thunderbolt dump, valid and invalid snapshot
    bus.i_tim_valid = 1'b1;
    push_report(8'hAC);
    send_cmd(8'hAC);
    wait_idle("tim_done", 1000);
    check("tim_freeze_idle", bus.o_tim_freeze, 0);
    bus.i_tim_valid = 1'b0;
    push_report(8'hAC);
    send_cmd(8'hAC);
    wait_idle("tim_invalid_done", 1000);
    bus.i_tim_valid = 1'b1;

    // Queue one command during a report, drop the next
    err0 = err_cnt; dv0 = dv_cnt;
    push_report(8'hAB);
    send_cmd(8'hAB);
    wait_dv("q_wait", dv0 + 3, 1000);
    push_report(8'hAC);
    send_cmd(8'hAC);
    repeat (5) @(negedge clk);
    send_cmd(8'hEE);
    wait_idle("q_done", 6000);
    check("q_err_count", err_cnt - err0, 1);

    // Unknown byte in IDLE
    err0 = err_cnt; dv0 = dv_cnt;
    send_cmd(8'h55);
    repeat (20) @(negedge clk);
    check("unknown_err", err_cnt - err0, 1);
    check("unknown_no_tx", dv_cnt - dv0, 0);
    check("unknown_idle", bus.o_busy, 0);

    // Long tx_active hold while in SEND
    hold_active = 1'b1;
    dv0 = dv_cnt;
    push_report(8'hEE);
    send_cmd(8'hEE);
    repeat (500) @(negedge clk);
    check("hold_no_dv", dv_cnt - dv0, 0);
    check("hold_in_send", dbg_state, 4);
    @(posedge clk); #1 hold_active = 1'b0;
    wait_idle("hold_done", 500);
    check("hold_dv_count", dv_cnt - dv0, 1 + trl);

    // Command arriving with the final tx_done
    err0 = err_cnt;
    inject_cmd = 8'hAC;
    inject_valid = 1'b1;
    push_report(8'hEE);
    send_cmd(8'hEE);
    wait_idle("inject_done", 2000);
    check("inject_used", inject_used, 1);
    check("inject_no_err", err_cnt - err0, 0);

    // Asynchronous reset mid-report
    dv0 = dv_cnt;
    push_report(8'hAB);
    send_cmd(8'hAB);
    wait_dv("rst_wait", dv0 + 7, 1000);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("midrst_no_dv", dv_cnt - dv0, 7);
    #5 rst_n = 1'b1;
    dv0 = dv_cnt;
    push_report(8'hAC);
    send_cmd(8'hAC);
    wait_idle("after_rst_done", 1000);
    check("after_rst_dv_count", dv_cnt - dv0, 8 + trl);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
